// File: rtl/atm_ledger_arbiter_if.sv
// Terminal-side bus of the shared-ledger arbiter: requests and amounts in, grant/completion/status out.
// The LIMITE_RETIRO_EN macro adds the withdrawal-limit clear input and the limit-rejection flag.
interface atm_ledger_arbiter_if #(
    parameter int N_TERM  = 4,
    parameter int MONTO_W = 32,
    parameter int BAL_W   = 64
);
    logic [N_TERM-1:0]         REQ;
    logic [N_TERM-1:0]         TIPO_TRANS;
    logic [N_TERM*MONTO_W-1:0] MONTO;
    logic [N_TERM-1:0]         GNT;
    logic [N_TERM-1:0]         DONE;
    logic                      FONDOS_INSUFICIENTES;
    logic [BAL_W-1:0]          BALANCE;
    logic                      OCUPADO;
`ifdef LIMITE_RETIRO_EN
    logic                      CLR_LIMITE;
    logic                      LIMITE_EXCEDIDO;

    modport master (
        output REQ, TIPO_TRANS, MONTO, CLR_LIMITE,
        input  GNT, DONE, FONDOS_INSUFICIENTES, BALANCE, OCUPADO, LIMITE_EXCEDIDO
    );
    modport slave (
        input  REQ, TIPO_TRANS, MONTO, CLR_LIMITE,
        output GNT, DONE, FONDOS_INSUFICIENTES, BALANCE, OCUPADO, LIMITE_EXCEDIDO
    );
`else
    modport master (
        output REQ, TIPO_TRANS, MONTO,
        input  GNT, DONE, FONDOS_INSUFICIENTES, BALANCE, OCUPADO
    );
    modport slave (
        input  REQ, TIPO_TRANS, MONTO,
        output GNT, DONE, FONDOS_INSUFICIENTES, BALANCE, OCUPADO
    );
`endif
endinterface

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter/sequencer serialising ATM withdraw/deposit transactions onto one balance register.
// Optional cumulative withdrawal limit is compiled in with the LIMITE_RETIRO_EN macro.
module atm_ledger_arbiter #(
    parameter int               N_TERM       = 4,
    parameter int               MONTO_W      = 32,
    parameter int               BAL_W        = 64,
    parameter logic [BAL_W-1:0] BALANCE_INIT = '0,
    parameter logic [BAL_W-1:0] LIMITE       = BAL_W'(32'd50000)
) (
    input  logic           CLK,
    input  logic           RESET,
    atm_ledger_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_TERM);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONCEDIDO = 2'd1,
        RESPUESTA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    sel_q, sel_d;
    logic                tipo_q, tipo_d;
    logic [MONTO_W-1:0]  monto_q, monto_d;
    logic [N_TERM-1:0]   gnt_q, gnt_d;
    logic [N_TERM-1:0]   done_q, done_d;
    logic                fondos_q, fondos_d;
    logic [BAL_W-1:0]    balance_q, balance_d;
    logic                ocupado_q, ocupado_d;

    logic [PTR_W-1:0]    pick_s;
    logic [BAL_W-1:0]    monto_ext_s;
    logic [BAL_W:0]      dep_sum_s;

    // Scan starts just after the last served terminal, so each one waits at most N_TERM-1 turns.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_TERM-1:0] req,
                                                 input logic [PTR_W-1:0]  ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_TERM; k++) begin
            idx = (int'(ptr) + k) % N_TERM;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_TERM-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_TERM-1:0] one;
        one = {{(N_TERM-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    assign pick_s      = rr_pick(bus.REQ, ptr_q);
    assign monto_ext_s = BAL_W'(monto_q);
    assign dep_sum_s   = {1'b0, balance_q} + {1'b0, monto_ext_s};

`ifdef LIMITE_RETIRO_EN
    logic [BAL_W-1:0] acum_q, acum_d;
    logic             limite_q, limite_d;
    logic [BAL_W:0]   acum_sum_s;
    logic             limit_hit_s;

    assign acum_sum_s  = {1'b0, acum_q} + {1'b0, monto_ext_s};
    assign limit_hit_s = (acum_sum_s > {1'b0, LIMITE});
`else
    logic unused_limite_s;
    assign unused_limite_s = ^LIMITE;
`endif

    // Next-state and datapath: operands are captured at grant and executed one cycle later.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        tipo_d    = tipo_q;
        monto_d   = monto_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        fondos_d  = fondos_q;
        balance_d = balance_q;
`ifdef LIMITE_RETIRO_EN
        limite_d  = limite_q;
        acum_d    = bus.CLR_LIMITE ? '0 : acum_q;
`endif
        case (state_q)
            REPOSO: begin
                if (|bus.REQ) begin
                    sel_d   = pick_s;
                    tipo_d  = bus.TIPO_TRANS[pick_s];
                    monto_d = bus.MONTO[int'(pick_s)*MONTO_W +: MONTO_W];
                    gnt_d   = onehot(pick_s);
                    state_d = CONCEDIDO;
                end else begin
                    state_d = REPOSO;
                end
            end
            CONCEDIDO: begin
                done_d   = onehot(sel_q);
                fondos_d = 1'b0;
`ifdef LIMITE_RETIRO_EN
                limite_d = 1'b0;
                // Limit rejection outranks the funds check; a coincident clear beats the accumulate.
                if (tipo_q) begin
                    if (limit_hit_s) begin
                        limite_d = 1'b1;
                    end else if (monto_ext_s <= balance_q) begin
                        balance_d = balance_q - monto_ext_s;
                        acum_d    = bus.CLR_LIMITE ? '0 : acum_sum_s[BAL_W-1:0];
                    end else begin
                        fondos_d = 1'b1;
                    end
`else
                if (tipo_q) begin
                    if (monto_ext_s <= balance_q) begin
                        balance_d = balance_q - monto_ext_s;
                    end else begin
                        fondos_d = 1'b1;
                    end
`endif
                end else if (dep_sum_s[BAL_W]) begin
                    balance_d = '1;
                end else begin
                    balance_d = dep_sum_s[BAL_W-1:0];
                end
                state_d = RESPUESTA;
            end
            RESPUESTA: begin
                gnt_d    = '0;
                done_d   = '0;
                fondos_d = 1'b0;
`ifdef LIMITE_RETIRO_EN
                limite_d = 1'b0;
`endif
                ptr_d    = sel_q;
                state_d  = REPOSO;
            end
            default: begin
                gnt_d    = '0;
                done_d   = '0;
                fondos_d = 1'b0;
                state_d  = REPOSO;
            end
        endcase
        ocupado_d = (state_d != REPOSO);
    end

    // Control and ledger registers; an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= REPOSO;
            ptr_q     <= PTR_W'(N_TERM - 1);
            sel_q     <= '0;
            tipo_q    <= 1'b0;
            monto_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            fondos_q  <= 1'b0;
            balance_q <= BALANCE_INIT;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            tipo_q    <= tipo_d;
            monto_q   <= monto_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            fondos_q  <= fondos_d;
            balance_q <= balance_d;
            ocupado_q <= ocupado_d;
        end
    end

`ifdef LIMITE_RETIRO_EN
    // Withdrawal accumulator and its rejection flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acum_q   <= '0;
            limite_q <= 1'b0;
        end else begin
            acum_q   <= acum_d;
            limite_q <= limite_d;
        end
    end

    assign bus.LIMITE_EXCEDIDO = limite_q;
`endif

    assign bus.GNT                  = gnt_q;
    assign bus.DONE                 = done_q;
    assign bus.FONDOS_INSUFICIENTES = fondos_q;
    assign bus.BALANCE              = balance_q;
    assign bus.OCUPADO              = ocupado_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Scoreboard bench for atm_ledger_arbiter: directed transactions push expectations, a DONE monitor checks them.
module tb_atm_ledger_arbiter;
    localparam int NT = 4;
    localparam int MW = 64;
    localparam int BW = 64;

    logic CLK;
    logic RESET;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        int          term;
        logic        fi;
        logic        lim;
        logic [63:0] bal;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    atm_ledger_arbiter_if #(.N_TERM(NT), .MONTO_W(MW), .BAL_W(BW)) bus ();

    atm_ledger_arbiter #(
        .N_TERM(NT), .MONTO_W(MW), .BAL_W(BW),
        .BALANCE_INIT(64'd0), .LIMITE(64'd1000)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (bus.DONE != '0) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got DONE=%b, expected none", bus.DONE);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_onehot", 64'(bus.DONE), 64'd1 << mon_e.term);
                check("gnt_onehot", 64'(bus.GNT), 64'd1 << mon_e.term);
                check("fondos", 64'(bus.FONDOS_INSUFICIENTES), 64'(mon_e.fi));
                check("balance", bus.BALANCE, mon_e.bal);
                check("ocupado", 64'(bus.OCUPADO), 64'd1);
`ifdef LIMITE_RETIRO_EN
                check("limite", 64'(bus.LIMITE_EXCEDIDO), 64'(mon_e.lim));
`endif
                if (mon_e.cyc >= 0) check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic check_reset();
        check("rst_gnt", 64'(bus.GNT), 64'd0);
        check("rst_done", 64'(bus.DONE), 64'd0);
        check("rst_fondos", 64'(bus.FONDOS_INSUFICIENTES), 64'd0);
        check("rst_ocupado", 64'(bus.OCUPADO), 64'd0);
        check("rst_balance", bus.BALANCE, 64'd0);
    endtask

    // Bounded wait at negedges until GNT (use_gnt=1) or DONE overlaps mask.
    task automatic wait_sig(input bit use_gnt, input logic [NT-1:0] mask);
        int n;
        logic hit;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            hit = use_gnt ? |(bus.GNT & mask) : |(bus.DONE & mask);
        end while (!hit && n < 20);
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got no %s on mask %b, expected within 20 cycles",
                     use_gnt ? "GNT" : "DONE", mask);
        end
    endtask

    task automatic push(input int t, input logic fi, input logic lim, input logic [63:0] bal, input int c);
        exp_t e;
        e.term = t; e.fi = fi; e.lim = lim; e.bal = bal; e.cyc = c;
        sb_q.push_back(e);
    endtask

    // One isolated transaction issued from idle: DONE due two cycles after REQ rises.
    task automatic txn(input int t, input logic wd, input logic [63:0] m,
                       input logic fi, input logic lim, input logic [63:0] bal);
        @(negedge CLK);
        push(t, fi, lim, bal, cyc + 2);
        bus.TIPO_TRANS[t]      = wd;
        bus.MONTO[t*MW +: MW]  = m;
        bus.REQ[t]             = 1'b1;
        wait_sig(1'b0, NT'(1) << t);
        bus.REQ[t] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        bus.REQ = '0;
        RESET   = 1'b0;
        #1;
        check_reset();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        int c0;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        RESET = 1'b0;
        bus.REQ = '0;
        bus.TIPO_TRANS = '0;
        bus.MONTO = '0;
`ifdef LIMITE_RETIRO_EN
        bus.CLR_LIMITE = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check_reset();
        RESET = 1'b1;

        // Deposit, exact-balance withdraw, overdraw, zero amounts.
        txn(0, 1'b0, 64'd500, 1'b0, 1'b0, 64'd500);
        txn(1, 1'b1, 64'd500, 1'b0, 1'b0, 64'd0);
        txn(1, 1'b1, 64'd1,   1'b1, 1'b0, 64'd0);
        txn(3, 1'b0, 64'd0,   1'b0, 1'b0, 64'd0);
        txn(3, 1'b1, 64'd0,   1'b0, 1'b0, 64'd0);

        // Terminal 2 drops REQ and changes MONTO after grant: latched 70 applies.
        @(negedge CLK);
        push(2, 1'b0, 1'b0, 64'd70, cyc + 2);
        bus.TIPO_TRANS[2] = 1'b0;
        bus.MONTO[2*MW +: MW] = 64'd70;
        bus.REQ[2] = 1'b1;
        wait_sig(1'b1, 4'b0100);
        bus.REQ[2] = 1'b0;
        bus.MONTO[2*MW +: MW] = 64'd999;
        wait_sig(1'b0, 4'b0100);

`ifdef LIMITE_RETIRO_EN
        @(negedge CLK);
        bus.CLR_LIMITE = 1'b1;
        @(negedge CLK);
        bus.CLR_LIMITE = 1'b0;
        txn(0, 1'b0, 64'd4930, 1'b0, 1'b0, 64'd5000);
        txn(1, 1'b1, 64'd800,  1'b0, 1'b0, 64'd4200);
        txn(1, 1'b1, 64'd300,  1'b0, 1'b1, 64'd4200);
        @(negedge CLK);
        bus.CLR_LIMITE = 1'b1;
        @(negedge CLK);
        bus.CLR_LIMITE = 1'b0;
        txn(1, 1'b1, 64'd300,  1'b0, 1'b0, 64'd3900);
`endif

        // All four request together after reset: order 0,1,2,3,0 with DONE every 3 cycles.
        do_reset();
        @(negedge CLK);
        c0 = cyc;
        for (int i = 0; i < 5; i++) push(i % NT, 1'b0, 1'b0, 64'(i + 1), c0 + 2 + 3 * i);
        bus.TIPO_TRANS = '0;
        for (int i = 0; i < NT; i++) bus.MONTO[i*MW +: MW] = 64'd1;
        bus.REQ = 4'b1111;
        for (int i = 0; i < 5; i++) wait_sig(1'b0, 4'b1111);
        bus.REQ = '0;

        // Saturating deposits near the top of the balance range.
        txn(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6);
        txn(2, 1'b0, 64'd100, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        txn(0, 1'b0, 64'd1,   1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset while granted: transaction aborted, outputs and ledger back to reset values at once.
        @(negedge CLK);
        bus.TIPO_TRANS[3] = 1'b0;
        bus.MONTO[3*MW +: MW] = 64'd5;
        bus.REQ[3] = 1'b1;
        wait_sig(1'b1, 4'b1000);
        RESET = 1'b0;
        #1;
        check_reset();
        bus.REQ = '0;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
